// File: rtl/xgmm.sv
`default_nettype none
// ============================================================================
//  Module   : xgmm
//  Purpose  : Graphics memory manager. Drains the pattern and attribute
//             upload FIFOs into their RAMs in fixed-length bursts while
//             giving renderer reads absolute priority on each RAM port.
//  Options  : XGMM_STALL_STAT_EN adds per-channel burst stall counters.
//  Revision : 1.0  initial release
// ============================================================================
module xgmm #(
    parameter int P_BURST = 16,
    parameter int A_BURST = 4
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        p_full,
    input  logic        a_full,
    input  logic [15:0] p_data,
    input  logic [15:0] a_data,
    input  logic [11:0] par,
    input  logic [12:0] aar,
    output logic        p_pop,
    output logic        a_pop,
    input  logic        pr_req,
    input  logic [15:0] pr_addr,
    output logic [15:0] pr_data,
    output logic        pr_valid,
    input  logic        ar_req,
    input  logic [12:0] ar_addr,
    output logic [15:0] ar_data,
    output logic        ar_valid,
    output logic [15:0] pm_addr,
    output logic        pm_wren,
    output logic [15:0] pm_wdata,
    input  logic [15:0] pm_rdata,
    output logic [12:0] am_addr,
    output logic        am_wren,
    output logic [15:0] am_wdata,
    input  logic [15:0] am_rdata
`ifdef XGMM_STALL_STAT_EN
    ,
    output logic [15:0] p_stall_cnt,
    output logic [15:0] a_stall_cnt
`endif
);

    localparam int c_PIW = $clog2(P_BURST);
    localparam int c_AIW = $clog2(A_BURST);
    localparam logic [c_PIW-1:0] c_P_LAST = c_PIW'(P_BURST - 1);
    localparam logic [c_AIW-1:0] c_A_LAST = c_AIW'(A_BURST - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    // ---------------- pattern channel ----------------
    state_t              p_state_q, p_state_d;
    logic [15-c_PIW:0]   p_base_q,  p_base_d;
    logic [c_PIW-1:0]    p_idx_q,   p_idx_d;
    logic                p_rd_pend_q;
    logic                p_wr;

    // Pattern burst sequencing: start when full and the renderer is idle,
    // write one word per cycle the renderer leaves the port free.
    always_comb begin
        p_state_d = p_state_q;
        p_base_d  = p_base_q;
        p_idx_d   = p_idx_q;
        p_wr      = 1'b0;
        case (p_state_q)
            S_IDLE: begin
                if (p_full && !pr_req) begin
                    p_state_d = S_BURST;
                    p_base_d  = par[15-c_PIW:0];
                    p_idx_d   = '0;
                end
            end
            S_BURST: begin
                if (!pr_req) begin
                    p_wr    = 1'b1;
                    p_idx_d = p_idx_q + 1'b1;
                    if (p_idx_q == c_P_LAST) begin
                        p_state_d = S_IDLE;
                    end
                end
            end
            default: p_state_d = S_IDLE;
        endcase
    end

    // Pattern channel state registers.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            p_state_q   <= S_IDLE;
            p_base_q    <= '0;
            p_idx_q     <= '0;
            p_rd_pend_q <= 1'b0;
        end else begin
            p_state_q   <= p_state_d;
            p_base_q    <= p_base_d;
            p_idx_q     <= p_idx_d;
            p_rd_pend_q <= pr_req;
        end
    end

    // Pattern address is a plain concatenation; the renderer owns the port
    // whenever no write is happening.
    assign p_pop    = p_wr;
    assign pm_wren  = p_wr;
    assign pm_wdata = p_data;
    assign pm_addr  = p_wr ? {p_base_q, p_idx_q} : pr_addr;
    assign pr_valid = p_rd_pend_q;
    assign pr_data  = pm_rdata;

    // ---------------- attribute channel ----------------
    state_t              a_state_q, a_state_d;
    logic [12:0]         a_base_q,  a_base_d;
    logic [c_AIW-1:0]    a_idx_q,   a_idx_d;
    logic                a_rd_pend_q;
    logic                a_wr;

    // Attribute burst sequencing, same shape as the pattern channel.
    always_comb begin
        a_state_d = a_state_q;
        a_base_d  = a_base_q;
        a_idx_d   = a_idx_q;
        a_wr      = 1'b0;
        case (a_state_q)
            S_IDLE: begin
                if (a_full && !ar_req) begin
                    a_state_d = S_BURST;
                    a_base_d  = aar;
                    a_idx_d   = '0;
                end
            end
            S_BURST: begin
                if (!ar_req) begin
                    a_wr    = 1'b1;
                    a_idx_d = a_idx_q + 1'b1;
                    if (a_idx_q == c_A_LAST) begin
                        a_state_d = S_IDLE;
                    end
                end
            end
            default: a_state_d = S_IDLE;
        endcase
    end

    // Attribute channel state registers.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            a_state_q   <= S_IDLE;
            a_base_q    <= '0;
            a_idx_q     <= '0;
            a_rd_pend_q <= 1'b0;
        end else begin
            a_state_q   <= a_state_d;
            a_base_q    <= a_base_d;
            a_idx_q     <= a_idx_d;
            a_rd_pend_q <= ar_req;
        end
    end

    // Attribute address is base plus index, wrapping at 13 bits.
    assign a_pop    = a_wr;
    assign am_wren  = a_wr;
    assign am_wdata = a_data;
    assign am_addr  = a_wr ? (a_base_q + 13'(a_idx_q)) : ar_addr;
    assign ar_valid = a_rd_pend_q;
    assign ar_data  = am_rdata;

`ifdef XGMM_STALL_STAT_EN
    logic [15:0] p_stall_q;
    logic [15:0] a_stall_q;

    // Saturating counts of burst cycles lost to renderer reads.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            p_stall_q <= '0;
            a_stall_q <= '0;
        end else begin
            if (p_state_q == S_IDLE && p_state_d == S_BURST) begin
                p_stall_q <= '0;
            end else if (p_state_q == S_BURST && pr_req && p_stall_q != 16'hFFFF) begin
                p_stall_q <= p_stall_q + 1'b1;
            end
            if (a_state_q == S_IDLE && a_state_d == S_BURST) begin
                a_stall_q <= '0;
            end else if (a_state_q == S_BURST && ar_req && a_stall_q != 16'hFFFF) begin
                a_stall_q <= a_stall_q + 1'b1;
            end
        end
    end

    assign p_stall_cnt = p_stall_q;
    assign a_stall_cnt = a_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xgmm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xgmm
//  Purpose  : Directed self-checking bench for xgmm with behavioural FIFOs
//             and single-port synchronous RAMs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xgmm;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        p_full, a_full;
    logic [15:0] p_data, a_data;
    logic [11:0] par;
    logic [12:0] aar;
    logic        p_pop, a_pop;
    logic        pr_req;
    logic [15:0] pr_addr;
    logic [15:0] pr_data;
    logic        pr_valid;
    logic        ar_req;
    logic [12:0] ar_addr;
    logic [15:0] ar_data;
    logic        ar_valid;
    logic [15:0] pm_addr, pm_wdata, pm_rdata;
    logic        pm_wren;
    logic [12:0] am_addr;
    logic [15:0] am_wdata, am_rdata;
    logic        am_wren;
`ifdef XGMM_STALL_STAT_EN
    logic [15:0] p_stall_cnt, a_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_sys = ~clk_sys;

    xgmm dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .p_full   (p_full),
        .a_full   (a_full),
        .p_data   (p_data),
        .a_data   (a_data),
        .par      (par),
        .aar      (aar),
        .p_pop    (p_pop),
        .a_pop    (a_pop),
        .pr_req   (pr_req),
        .pr_addr  (pr_addr),
        .pr_data  (pr_data),
        .pr_valid (pr_valid),
        .ar_req   (ar_req),
        .ar_addr  (ar_addr),
        .ar_data  (ar_data),
        .ar_valid (ar_valid),
        .pm_addr  (pm_addr),
        .pm_wren  (pm_wren),
        .pm_wdata (pm_wdata),
        .pm_rdata (pm_rdata),
        .am_addr  (am_addr),
        .am_wren  (am_wren),
        .am_wdata (am_wdata),
        .am_rdata (am_rdata)
`ifdef XGMM_STALL_STAT_EN
        ,
        .p_stall_cnt (p_stall_cnt),
        .a_stall_cnt (a_stall_cnt)
`endif
    );

    // Upstream FIFOs: first-word fall-through, full at burst length.
    logic [15:0] pfifo [0:15];
    logic [15:0] afifo [0:3];
    int p_wr = 0, p_rd = 0, a_wr = 0, a_rd = 0;

    assign p_full = ((p_wr - p_rd) == 16);
    assign a_full = ((a_wr - a_rd) == 4);
    assign p_data = pfifo[p_rd[3:0]];
    assign a_data = afifo[a_rd[1:0]];

    always @(posedge clk_sys) begin
        if (p_pop) p_rd <= p_rd + 1;
        if (a_pop) a_rd <= a_rd + 1;
    end

    // Single-port RAMs with one cycle read latency.
    logic [15:0] pram [0:65535];
    logic [15:0] aram [0:8191];

    always @(posedge clk_sys) begin
        if (pm_wren) pram[pm_addr] <= pm_wdata;
        pm_rdata <= pram[pm_addr];
        if (am_wren) aram[am_addr] <= am_wdata;
        am_rdata <= aram[am_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_p(input logic [15:0] v);
        pfifo[p_wr[3:0]] = v;
        p_wr = p_wr + 1;
    endtask

    task automatic push_a(input logic [15:0] v);
        afifo[a_wr[1:0]] = v;
        a_wr = a_wr + 1;
    endtask

    logic [12:0] wrap_addr [0:3];

    initial begin
        rst     = 1'b1;
        par     = 12'h000;
        aar     = 13'h0000;
        pr_req  = 1'b0;
        ar_req  = 1'b0;
        pr_addr = 16'h1234;
        ar_addr = 13'h0ABC;
        wrap_addr[0] = 13'h1FFE;
        wrap_addr[1] = 13'h1FFF;
        wrap_addr[2] = 13'h0000;
        wrap_addr[3] = 13'h0001;

        // ---- reset state ----
        #12;
        chk("rst_pm_wren", 32'(pm_wren), 0);
        chk("rst_p_pop",   32'(p_pop), 0);
        chk("rst_am_wren", 32'(am_wren), 0);
        chk("rst_a_pop",   32'(a_pop), 0);
        chk("rst_pr_valid", 32'(pr_valid), 0);
        chk("rst_ar_valid", 32'(ar_valid), 0);
        chk("rst_pm_addr", 32'(pm_addr), 'h1234);
        chk("rst_am_addr", 32'(am_addr), 'h0ABC);
        @(negedge clk_sys);
        rst = 1'b0;

        // ---- pattern burst at par=0x012 ----
        @(negedge clk_sys);
        par = 12'h012;
        for (int i = 0; i < 16; i++) push_p(16'(32'hA000 + i));
        #1;
        chk("t1_entry_wren", 32'(pm_wren), 0);
        chk("t1_entry_pop",  32'(p_pop), 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_sys); #1;
            chk($sformatf("t1_wren%0d", i), 32'(pm_wren), 1);
            chk($sformatf("t1_addr%0d", i), 32'(pm_addr), 'h0120 + i);
            chk($sformatf("t1_data%0d", i), 32'(pm_wdata), 'hA000 + i);
            chk($sformatf("t1_pop%0d", i), 32'(p_pop), 1);
        end
        @(negedge clk_sys); #1;
        chk("t1_done_wren", 32'(pm_wren), 0);
        chk("t1_done_pop",  32'(p_pop), 0);

        // ---- attribute burst wrapping at 0x1FFF ----
        @(negedge clk_sys);
        aar = 13'h1FFE;
        for (int i = 0; i < 4; i++) push_a(16'(32'hB000 + i));
        #1;
        chk("t2_entry_wren", 32'(am_wren), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys); #1;
            chk($sformatf("t2_wren%0d", i), 32'(am_wren), 1);
            chk($sformatf("t2_addr%0d", i), 32'(am_addr), 32'(wrap_addr[i]));
            chk($sformatf("t2_data%0d", i), 32'(am_wdata), 'hB000 + i);
            chk($sformatf("t2_pop%0d", i), 32'(a_pop), 1);
        end
        @(negedge clk_sys); #1;
        chk("t2_done_wren", 32'(am_wren), 0);
        chk("t2_done_pop",  32'(a_pop), 0);

        // ---- pattern burst at par=0 with 3 stall cycles after 5th write ----
        @(negedge clk_sys);
        par = 12'h000;
        for (int i = 0; i < 16; i++) push_p(16'(32'hC000 + i));
        #1;
        chk("t3_entry_wren", 32'(pm_wren), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys); #1;
            chk($sformatf("t3_addr%0d", i), 32'(pm_addr), i);
            chk($sformatf("t3_wren%0d", i), 32'(pm_wren), 1);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_sys);
            pr_req  = 1'b1;
            pr_addr = 16'(32'h0120 + k);
            #1;
            chk($sformatf("t3_stall_wren%0d", k), 32'(pm_wren), 0);
            chk($sformatf("t3_stall_pop%0d", k), 32'(p_pop), 0);
            chk($sformatf("t3_stall_addr%0d", k), 32'(pm_addr), 'h0120 + k);
            if (k > 0) begin
                chk($sformatf("t3_stall_valid%0d", k), 32'(pr_valid), 1);
                chk($sformatf("t3_stall_rdata%0d", k), 32'(pr_data), 'hA000 + k - 1);
            end
        end
        for (int i = 5; i < 16; i++) begin
            @(negedge clk_sys);
            pr_req = 1'b0;
            #1;
            chk($sformatf("t3_addr%0d", i), 32'(pm_addr), i);
            chk($sformatf("t3_data%0d", i), 32'(pm_wdata), 'hC000 + i);
            chk($sformatf("t3_pop%0d", i), 32'(p_pop), 1);
            if (i == 5) begin
                chk("t3_last_valid", 32'(pr_valid), 1);
                chk("t3_last_rdata", 32'(pr_data), 'hA002);
            end
            if (i == 6) chk("t3_valid_drop", 32'(pr_valid), 0);
        end
        @(negedge clk_sys); #1;
        chk("t3_done_wren", 32'(pm_wren), 0);
`ifdef XGMM_STALL_STAT_EN
        chk("t3_stall_cnt", 32'(p_stall_cnt), 3);
        chk("t3_a_stall_cnt", 32'(a_stall_cnt), 0);
`endif

        // ---- back-to-back renderer reads in IDLE ----
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_sys);
            pr_req  = 1'b1;
            pr_addr = 16'(k + 1);
            ar_req  = (k == 0);
            ar_addr = 13'h1FFF;
            #1;
            chk($sformatf("t4_pm_addr%0d", k), 32'(pm_addr), k + 1);
            if (k == 0) begin
                chk("t4_valid_pre", 32'(pr_valid), 0);
                chk("t4_avalid_pre", 32'(ar_valid), 0);
            end else begin
                chk($sformatf("t4_valid%0d", k), 32'(pr_valid), 1);
                chk($sformatf("t4_rdata%0d", k), 32'(pr_data), 'hC000 + k);
            end
            if (k == 1) begin
                chk("t4_avalid", 32'(ar_valid), 1);
                chk("t4_ardata", 32'(ar_data), 'hB001);
            end
            if (k == 2) chk("t4_avalid_drop", 32'(ar_valid), 0);
        end
        @(negedge clk_sys);
        pr_req = 1'b0;
        #1;
        chk("t4_valid4", 32'(pr_valid), 1);
        chk("t4_rdata4", 32'(pr_data), 'hC004);
        @(negedge clk_sys); #1;
        chk("t4_valid_drop", 32'(pr_valid), 0);

        // ---- concurrent pattern and attribute bursts ----
        @(negedge clk_sys);
        par = 12'h055;
        aar = 13'h0100;
        for (int i = 0; i < 16; i++) push_p(16'(32'hD000 + i));
        for (int i = 0; i < 4; i++) push_a(16'(32'hE000 + i));
        #1;
        chk("t5_entry_pwren", 32'(pm_wren), 0);
        chk("t5_entry_awren", 32'(am_wren), 0);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_sys); #1;
            chk($sformatf("t5_paddr%0d", c), 32'(pm_addr), 'h0550 + c);
            chk($sformatf("t5_pdata%0d", c), 32'(pm_wdata), 'hD000 + c);
            if (c < 4) begin
                chk($sformatf("t5_aaddr%0d", c), 32'(am_addr), 'h0100 + c);
                chk($sformatf("t5_adata%0d", c), 32'(am_wdata), 'hE000 + c);
            end else begin
                chk($sformatf("t5_awren%0d", c), 32'(am_wren), 0);
            end
`ifdef XGMM_STALL_STAT_EN
            if (c == 0) chk("t5_stall_clr", 32'(p_stall_cnt), 0);
`endif
        end
        @(negedge clk_sys); #1;
        chk("t5_done_pwren", 32'(pm_wren), 0);
        chk("t5_done_awren", 32'(am_wren), 0);

        // ---- reset in the middle of a burst ----
        @(negedge clk_sys);
        par = 12'h066;
        for (int i = 0; i < 16; i++) push_p(16'(32'hF000 + i));
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_sys); #1;
            chk($sformatf("t6_addr%0d", i), 32'(pm_addr), 'h0660 + i);
        end
        @(negedge clk_sys); #1;
        chk("t6_pre_rst_wren", 32'(pm_wren), 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_wren", 32'(pm_wren), 0);
        chk("t6_rst_pop",  32'(p_pop), 0);
        chk("t6_rst_addr", 32'(pm_addr), 32'(pr_addr));
        p_wr = p_rd;
        @(negedge clk_sys);
        rst = 1'b0;
        #1;
        chk("t6_idle_wren", 32'(pm_wren), 0);
        @(negedge clk_sys);
        par = 12'h077;
        for (int i = 0; i < 16; i++) push_p(16'(32'h5000 + i));
        #1;
        chk("t6_entry_wren", 32'(pm_wren), 0);
        @(negedge clk_sys); #1;
        chk("t6_new_addr0", 32'(pm_addr), 'h0770);
        chk("t6_new_data0", 32'(pm_wdata), 'h5000);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk_sys); #1;
        end
        chk("t6_new_addr15", 32'(pm_addr), 'h077F);
        @(negedge clk_sys); #1;
        chk("t6_done_wren", 32'(pm_wren), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xgmm.md
Name: xgmm

Overview:
- Graphics memory manager; directly downstream of the graphics register interface.
- Drains the pattern FIFO (16 words) and attribute FIFO (4 words) into pattern RAM and attribute RAM.
- Arbitrates each RAM's single port between these upload bursts and renderer reads; the renderer always wins.

Parameters:
- P_BURST, 16, words per pattern upload; power of two; pattern RAM address = {par, index}.
- A_BURST, 4, words per attribute upload; attribute RAM address = aar + index.

Ports:
- clk_sys  in  1  system clock
- rst  in  1  asynchronous active-high reset
- p_full  in  1  pattern FIFO holds P_BURST words
- a_full  in  1  attribute FIFO holds A_BURST words
- p_data  in  16  pattern FIFO head (first-word fall-through)
- a_data  in  16  attribute FIFO head (first-word fall-through)
- par  in  12  pattern upload base
- aar  in  13  attribute upload base
- p_pop  out  1  pop pattern FIFO
- a_pop  out  1  pop attribute FIFO
- pr_req  in  1  renderer pattern read request
- pr_addr  in  16  renderer pattern word address
- pr_data  out  16  pattern read data
- pr_valid  out  1  pr_data valid
- ar_req  in  1  renderer attribute read request
- ar_addr  in  13  renderer attribute word address
- ar_data  out  16  attribute read data
- ar_valid  out  1  ar_data valid
- pm_addr  out  16  pattern RAM address
- pm_wren  out  1  pattern RAM write enable
- pm_wdata  out  16  pattern RAM write data
- pm_rdata  in  16  pattern RAM read data, 1-cycle synchronous latency
- am_addr  out  13  attribute RAM address
- am_wren  out  1  attribute RAM write enable
- am_wdata  out  16  attribute RAM write data
- am_rdata  in  16  attribute RAM read data, 1-cycle synchronous latency

Behaviour:
- The pattern channel and attribute channel are identical and fully independent. Pattern is described; attribute substitutes a/ar/am/aar/A_BURST.
- Per-channel FSM states: IDLE, BURST. Registers: base (latched par or aar), idx (log2(P_BURST) or log2(A_BURST) bits), rd_pend.
- IDLE -> BURST when p_full=1 and pr_req=0:
  - latch base<=par, idx<=0.
  - No write occurs in the transition cycle.
- Write cycle (BURST and pr_req=0):
  - pm_wren=1, pm_addr={base,idx}, pm_wdata=p_data, p_pop=1 (all combinational), idx<=idx+1.
  - The write at idx=P_BURST-1 returns the FSM to IDLE.
- Stall cycle (BURST and pr_req=1):
  - pm_addr=pr_addr, pm_wren=0, p_pop=0; idx holds.
  - The burst resumes in the next cycle with pr_req=0.
- Renderer reads are always accepted, in any state:
  - rd_pend<=pr_req; pr_valid=rd_pend; pr_data=pm_rdata.
  - Data appears exactly 1 cycle after the request; back-to-back requests are supported.
- Attribute address arithmetic: aar+idx, modulo 2^13 (wraps 0x1FFF -> 0x0000). Pattern address is a pure concatenation with no carry.
- p_pop is asserted only on write cycles. Exactly P_BURST pops occur per burst, so upstream sees empty and advances par by 1 (aar by 4).
- Software must not push to a FIFO while its burst is in progress. xgmm does not detect a violation: the burst still ends after P_BURST pops.
- p_full re-asserted during the final write cycle is ignored until IDLE is re-evaluated in the following cycle.
- Reset (asynchronous, any state): FSM=IDLE, idx=0, rd_pend=0.
  - p_pop, pm_wren, pr_valid, a_pop, am_wren and ar_valid go to 0 immediately.
  - pr_data and ar_data follow RAM data (don't-care while valid=0).
  - pm_addr=pr_addr and am_addr=ar_addr.
  - A partial burst is abandoned; upstream FIFOs are reset by the same rst.

Optional Feature:
- Macro XGMM_STALL_STAT_EN. When defined, adds:
  - output p_stall_cnt[15:0]: counts BURST cycles stalled by pr_req.
  - output a_stall_cnt[15:0]: counts BURST cycles stalled by ar_req.
  - Each counter saturates at 0xFFFF, clears on rst, and clears when its channel enters BURST.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- par=0x012, p_full rises, pr_req=0 -> enter BURST next cycle; then 16 consecutive cycles with pm_wren=1, pm_addr=0x0120..0x012F, data in FIFO order, 16 p_pop; then IDLE.
- aar=0x1FFE, a_full rises -> 4 writes at am_addr 0x1FFE, 0x1FFF, 0x0000, 0x0001; 4 a_pop.
- Pattern burst with pr_req=1 for 3 cycles after the 5th write -> 3 cycles with pm_wren=0, pm_addr=pr_addr, p_pop=0; writes resume at idx 5; 19 BURST cycles total; stall counter=3 when enabled.
- pr_req held 4 cycles in IDLE, addresses 0x0001..0x0004 -> pr_valid high 4 cycles, each delayed 1 cycle, pr_data matches RAM contents.
- p_full and a_full rise in the same cycle -> both bursts run concurrently (16 and 4 writes), with no interaction.
- rst pulse after the 7th pattern write -> p_pop and pm_wren drop immediately; FSM is IDLE after release; a new p_full starts idx at 0.
